// File: rtl/pipeline_pkg.sv
// Shared constants for the two-pair multiply-accumulate pipeline.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  // Register stages from operand capture to C.
  localparam int LATENCY = 3;

endpackage

// File: rtl/pipeline_mul.sv
// Combinational unsigned multiply, result truncated to the operand width.
module pipeline_mul
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  // The assignment context is WIDTH bits, so only the low half of the product is kept.
  assign p = a * b;

endmodule

// File: rtl/pipeline.sv
// Three-stage pipeline computing C = A1*B1 + A2*B2 (mod 2^WIDTH).
// S1 registers operands, S2 registers the two truncated products, S3 registers the sum.
module pipeline
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] C
);

  logic [WIDTH-1:0] s1_a1, s1_b1, s1_a2, s1_b2;
  logic [WIDTH-1:0] p1, p2;
  logic [WIDTH-1:0] s2_p1, s2_p2;
  logic [WIDTH-1:0] s3_sum;

  // S1: capture the operand set presented at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a1 <= '0;
      s1_b1 <= '0;
      s1_a2 <= '0;
      s1_b2 <= '0;
    end else begin
      s1_a1 <= A1;
      s1_b1 <= B1;
      s1_a2 <= A2;
      s1_b2 <= B2;
    end
  end

  pipeline_mul #(.WIDTH(WIDTH)) u_mul1 (
    .a (s1_a1),
    .b (s1_b1),
    .p (p1)
  );

  pipeline_mul #(.WIDTH(WIDTH)) u_mul2 (
    .a (s1_a2),
    .b (s1_b2),
    .p (p2)
  );

  // S2: register both truncated products.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_p1 <= '0;
      s2_p2 <= '0;
    end else begin
      s2_p1 <= p1;
      s2_p2 <= p2;
    end
  end

  // S3: register the wrapped sum; this register drives C directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_sum <= '0;
    end else begin
      s3_sum <= s2_p1 + s2_p2;
    end
  end

  assign C = s3_sum;

endmodule

// File: tb/tb_pipeline.sv
// Self-checking bench for pipeline: directed vectors plus randomized traffic
// compared against a history-based reference model.
module tb_pipeline;
  import pipeline_pkg::*;

  localparam int W = DATA_W;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A1, B1, A2, B2;
  logic [W-1:0] C;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per rising edge holding the sampled result and reset state.
  logic [W-1:0] val_q[$];
  logic         rst_q[$];

  pipeline #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (A1),
    .B1    (B1),
    .A2    (A2),
    .B2    (B2),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mac(input logic [W-1:0] a1, b1, a2, b2);
    logic [W-1:0] r;
    r = a1 * b1 + a2 * b2;
    return r;
  endfunction

  // One clock: drive (optionally with mid-cycle glitches), pass a rising edge,
  // return C just after the edge and the model's expectation. Returns at negedge.
  task automatic step(input logic [W-1:0] a1, b1, a2, b2, input logic rst_lvl,
                      input logic glitch, output logic [W-1:0] exp,
                      output logic [W-1:0] c_early);
    if (glitch) begin
      A1 = $urandom; B1 = $urandom; A2 = $urandom; B2 = $urandom;
      rst_n = ~rst_lvl;
      #1;
    end
    A1 = a1; B1 = b1; A2 = a2; B2 = b2;
    rst_n = rst_lvl;
    @(posedge clk);
    val_q.push_back(mac(a1, b1, a2, b2));
    rst_q.push_back(!rst_lvl);
    if (val_q.size() > LATENCY) begin
      void'(val_q.pop_front());
      void'(rst_q.pop_front());
    end
    #1 c_early = C;
    @(negedge clk);
    if (rst_q[0] || rst_q[1] || rst_q[2]) exp = '0;
    else exp = val_q[0];
  endtask

  task automatic test_reset();
    logic [W-1:0] e, ce;
    for (int i = 0; i < 2; i++) begin
      step('0, '0, '0, '0, 1'b0, 1'b0, e, ce);
      checks++;
      if (C !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: C=%h want 0", i, C);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step('0, '0, '0, '0, 1'b1, 1'b0, e, ce);
      checks++;
      if (C !== '0 || ce !== '0) begin
        errors++;
        $display("FAIL reset_release_zero cyc%0d: C=%h early=%h want 0", i, C, ce);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, ce;
    logic [W-1:0] want[4] = '{32'd0, 32'd0, 32'd6, 32'd6};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(32'd0, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0, e, ce);
        1: step(32'd3, 32'd2, 32'd1, 32'd0, 1'b1, 1'b0, e, ce);
        default: step('0, '0, '0, '0, 1'b1, 1'b0, e, ce);
      endcase
      checks++;
      if (C !== want[i] || ce !== want[i] || C !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: C=%h early=%h want %h", i, C, ce, want[i]);
      end
    end
  endtask

  task automatic test_truncation();
    logic [W-1:0] e, ce;
    logic [W-1:0] want[4] = '{32'd0, 32'd0, 32'h1, 32'h1};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, e, ce);
        1: step(32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, e, ce);
        default: step('0, '0, '0, '0, 1'b1, 1'b0, e, ce);
      endcase
      checks++;
      if (C !== want[i] || C !== e) begin
        errors++;
        $display("FAIL truncation cyc%0d: C=%h want %h", i, C, want[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] e, ce;
    logic [W-1:0] want[5] = '{32'd0, 32'd0, 32'd2, 32'd8, 32'd18};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(W'(i + 1), W'(i + 1), W'(i + 1), W'(i + 1), 1'b1, 1'b0, e, ce);
      else       step('0, '0, '0, '0, 1'b1, 1'b0, e, ce);
      checks++;
      if (C !== want[i] || C !== e) begin
        errors++;
        $display("FAIL stream cyc%0d: C=%h want %h", i, C, want[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [W-1:0] e, ce;
    step(32'd5, 32'd5, 32'd5, 32'd5, 1'b1, 1'b0, e, ce);
    step(32'd7, 32'd7, 32'd7, 32'd7, 1'b1, 1'b0, e, ce);
    step(32'd9, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0, e, ce);
    checks++;
    if (C !== '0) begin
      errors++;
      $display("FAIL flush_reset_edge: C=%h want 0", C);
    end
    for (int i = 0; i < 4; i++) begin
      step('0, '0, '0, '0, 1'b1, 1'b0, e, ce);
      checks++;
      if (C !== '0 || ce !== '0) begin
        errors++;
        $display("FAIL flush_after cyc%0d: C=%h early=%h want 0", i, C, ce);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e, ce, v;
    v = mac(32'd123, 32'd456, 32'd789, 32'd1011);
    for (int i = 0; i < 6; i++) begin
      step(32'd123, 32'd456, 32'd789, 32'd1011, 1'b1, 1'b1, e, ce);
      if (i >= 2) begin
        checks++;
        if (C !== v || ce !== v) begin
          errors++;
          $display("FAIL hold cyc%0d: C=%h early=%h want %h", i, C, ce, v);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, ce;
    logic [W-1:0] a1, b1, a2, b2;
    logic         r;
    for (int i = 0; i < 300; i++) begin
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a1 = a1 & 32'hFF; b1 = b1 & 32'hFF;
      end
      r = ($urandom_range(0, 19) != 0);
      step(a1, b1, a2, b2, r, ($urandom_range(0, 3) == 0), e, ce);
      checks++;
      if (C !== e || ce !== e) begin
        errors++;
        $display("FAIL random cyc%0d: C=%h early=%h want %h", i, C, ce, e);
      end
    end
  endtask

  initial begin
    A1 = '0; B1 = '0; A2 = '0; B2 = '0;
    rst_n = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      val_q.push_back('0);
      rst_q.push_back(1'b1);
    end
    test_reset();
    test_back_to_back();
    test_truncation();
    test_stream();
    test_reset_flush();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline.md
PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port A1, input, WIDTH bits: first multiplicand of product pair 1.
REQ-005 The block SHALL have port B1, input, WIDTH bits: second multiplicand of product pair 1.
REQ-006 The block SHALL have port A2, input, WIDTH bits: first multiplicand of product pair 2.
REQ-007 The block SHALL have port B2, input, WIDTH bits: second multiplicand of product pair 2.
REQ-008 The block SHALL have port C, output, WIDTH bits: registered result (A1*B1 + A2*B2).

Function
REQ-009 Function: C = (A1*B1 + A2*B2) mod 2^WIDTH; operands unsigned; product and sum truncated to the low WIDTH bits; no overflow flag.
REQ-010 Three register stages: S1 captures A1,B1,A2,B2; S2 captures the two products P1=A1*B1 and P2=A2*B2, each truncated to WIDTH bits; S3 captures P1+P2 and drives C.
REQ-011 Latency: operands sampled at rising edge n SHALL appear on C immediately after edge n+2, and C SHALL hold that value until edge n+3.
REQ-012 Throughput: one new operand set is accepted on every edge, with no stall, handshake or bubble.
REQ-013 Inputs are sampled only at rising edges; input changes between edges SHALL NOT affect C.
REQ-014 C is a direct register output with no combinational path from any input to C.
REQ-015 When operands are held constant, C SHALL stay constant from the third edge onward.

Reset
REQ-016 When rst_n=0 at a rising edge, all stage registers (S1 operands, S2 products, S3 sum) SHALL clear to 0, so C=0 after that edge.
REQ-017 Reset mid-operation SHALL flush all in-flight results; none may appear on C after reset.
REQ-018 After rst_n returns to 1, C SHALL be 0 until the first post-reset operand set reaches C at edge n+2.
REQ-019 Reset SHALL take effect only at a clock edge; an rst_n pulse between edges has no effect.

Structure
REQ-020 A shared package pipeline_pkg SHALL hold the constants DATA_W=32 and LATENCY=3.
REQ-021 The multiply SHALL be a sub-module pipeline_mul: a combinational WIDTH x WIDTH multiply with truncated output, instantiated twice in front of S2.
REQ-022 The adder and all stage registers SHALL live in the top module pipeline.

Verification
REQ-023 Bench SHALL apply rst_n=0 for 2 edges, then release with all operands 0 -> C=0 on every cycle.
REQ-024 Bench SHALL apply A1=0, B1=1, A2=2, B2=3 at edge n -> C=6 after edge n+2.
REQ-025 Bench SHALL apply A1=3, B1=2, A2=1, B2=0 back-to-back with the REQ-024 set -> C=6 after edge n+2, then C=6 after edge n+3.
REQ-026 Bench SHALL apply A1=B1=0xFFFFFFFF, A2=B2=0 -> C=0x00000001 (truncation); then A1=0x80000000, B1=2, A2=B2=0xFFFFFFFF -> C=0x00000001.
REQ-027 Bench SHALL stream the sets (1,1,1,1), (2,2,2,2), (3,3,3,3) on consecutive edges -> C=2, 8, 18 on three consecutive cycles.
REQ-028 Bench SHALL assert rst_n=0 for one edge while two sets are in flight -> C=0 after that edge, and neither in-flight result ever appears on C.
